alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's combinational 32-bit ALU.
- Keeps the same opcode map and adds the following:
  - WIDTH parameter.
  - Variable shift amounts.
  - Iterative unsigned multiply.
  - Registered status flags.
- Sits between the issue stage and the writeback stage.
- Uses valid/ready on both sides so multi-cycle ops can stall the producer.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4, power of two).
- SHW (localparam), $clog2(WIDTH), shift-amount field width taken from datab.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- dataa  input  WIDTH  operand A.
- datab  input  WIDTH  operand B; for shifts, the amount is datab[SHW-1:0].
- Function  input  4  opcode.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- carry  output  1  carry / no-borrow.
- overflow  output  1  signed overflow (ADD/SUB) or product truncation (MUL).
- illegal  output  1  opcode not in the table below.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high. Port names are clk and reset.
  - While reset is high, at the next edge: state=IDLE; result, zero, carry, overflow, illegal and out_valid all cleared to 0.
  - in_ready=0 while reset is high.
  - Reset mid-MUL aborts the operation. No out_valid is produced for the aborted request.
- Opcodes:
  - ADD=0000, SUB=0010, MUL=0011, AND=0100, OR=0101, NOR=0110, XOR=0111, SL=1000, SRA=1001, SRL=1010.
  - Any other code: result=0, illegal=1, zero=1, carry=0, overflow=0. Single-cycle latency.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE) && !reset.
  - out_valid = (state==DONE).
- Accept: in_valid && in_ready at an edge. dataa, datab and Function are sampled at that edge only.
- Single-cycle ops (all except MUL):
  - Result and flags are registered at the accept edge. State goes to DONE.
  - out_valid is high the cycle after accept (latency 1).
- MUL:
  - Accept edge loads the multiplicand, multiplier, a 2*WIDTH accumulator and a step counter=WIDTH. State goes to BUSY.
  - Each BUSY edge performs one shift-add step and decrements the counter.
  - The edge that completes step WIDTH writes result = low WIDTH bits and goes to DONE.
  - out_valid rises exactly WIDTH edges after the accept edge.
- DONE:
  - result and flags are held stable until an edge with out_ready=1; state then goes to IDLE.
  - No new request is accepted in the same cycle. Throughput: one op per 2 cycles minimum.
- Arithmetic:
  - ADD carry = carry-out of bit WIDTH-1.
  - SUB computes dataa + ~datab + 1; carry = 1 when dataa >= datab unsigned (no borrow).
  - Overflow for ADD/SUB: operand signs as required and the result sign differs.
  - MUL overflow = 1 if the upper WIDTH bits of the product are nonzero; MUL carry = 0.
  - Logic ops and shifts: carry=0, overflow=0.
- Shifts:
  - Amount n = datab[SHW-1:0]; upper datab bits are ignored.
  - n=0 passes dataa unchanged.
  - SL fills with 0, SRL fills with 0, SRA fills with dataa[WIDTH-1].
- zero is computed from the registered result for every opcode.
- Input changes during BUSY/DONE have no effect. in_valid held high while in_ready=0 is simply not accepted.

Test Plan (WIDTH=32):
1. ADD with dataa=0xFFFFFFFF, datab=1, out_ready=1 -> result 0x00000000, zero=1, carry=1, overflow=0; out_valid for exactly 1 cycle, starting the cycle after accept; in_ready back to 1 the following cycle.
2. SUB with dataa=0x80000000, datab=1 -> result 0x7FFFFFFF, carry=1, overflow=1. SUB with dataa=1, datab=2 -> 0xFFFFFFFF, carry=0, overflow=0.
3. SRA with dataa=0x80000000, datab=0x24 -> shift 4, result 0xF8000000. SRL with the same inputs -> 0x08000000. SL with dataa=0x1, datab=0 -> 0x1.
4. MUL with dataa=0x00010000, datab=0x00010000 -> result 0, overflow=1, zero=1; out_valid 32 edges after accept. MUL with 7 x 6 -> 0x2A, overflow=0.
5. Backpressure: ADD 3+4 completes, out_ready held 0 for 5 cycles with in_valid=1 and changing operands -> result stays 0x7, out_valid stays 1, in_ready stays 0; on the out_ready=1 edge -> IDLE, then the pending request is accepted.
6. Reset at step 10 of a MUL -> no out_valid and in_ready=1 the cycle after reset deasserts; a following opcode 4'b1111 -> illegal=1, result=0, zero=1, latency 1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle between the issue stage, the sequential ALU and writeback.
// The issue/writeback side uses the master modport; the ALU uses the slave modport.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic [3:0]       Function;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, dataa, datab, Function, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, illegal
    );

    modport slave (
        input  in_valid, dataa, datab, Function, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus an iterative shift-add
// unsigned multiply. Results and flags are held in registers until the consumer accepts them.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpMul = 4'b0011;
    localparam logic [3:0] OpAnd = 4'b0100;
    localparam logic [3:0] OpOr  = 4'b0101;
    localparam logic [3:0] OpNor = 4'b0110;
    localparam logic [3:0] OpXor = 4'b0111;
    localparam logic [3:0] OpSl  = 4'b1000;
    localparam logic [3:0] OpSra = 4'b1001;
    localparam logic [3:0] OpSrl = 4'b1010;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               carry_q;
    logic               overflow_q;
    logic               illegal_q;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   sc_result;
    logic               sc_carry;
    logic               sc_overflow;
    logic               sc_illegal;
    logic [2*WIDTH-1:0] acc_nxt;

    // Single-cycle datapath, evaluated on the live request operands.
    always_comb begin
        add_full    = {1'b0, bus.dataa} + {1'b0, bus.datab};
        sub_full    = {1'b0, bus.dataa} + {1'b0, ~bus.datab} + (WIDTH + 1)'(1);
        shamt       = bus.datab[SHW-1:0];
        sc_result   = '0;
        sc_carry    = 1'b0;
        sc_overflow = 1'b0;
        sc_illegal  = 1'b0;
        case (bus.Function)
            OpAdd: begin
                sc_result   = add_full[WIDTH-1:0];
                sc_carry    = add_full[WIDTH];
                sc_overflow = (bus.dataa[WIDTH-1] == bus.datab[WIDTH-1]) &&
                              (add_full[WIDTH-1] != bus.dataa[WIDTH-1]);
            end
            OpSub: begin
                sc_result   = sub_full[WIDTH-1:0];
                sc_carry    = sub_full[WIDTH];
                sc_overflow = (bus.dataa[WIDTH-1] != bus.datab[WIDTH-1]) &&
                              (sub_full[WIDTH-1] != bus.dataa[WIDTH-1]);
            end
            OpAnd:   sc_result = bus.dataa & bus.datab;
            OpOr:    sc_result = bus.dataa | bus.datab;
            OpNor:   sc_result = ~(bus.dataa | bus.datab);
            OpXor:   sc_result = bus.dataa ^ bus.datab;
            OpSl:    sc_result = bus.dataa << shamt;
            OpSra:   sc_result = $signed(bus.dataa) >>> shamt;
            OpSrl:   sc_result = bus.dataa >> shamt;
            OpMul:   sc_result = '0;
            default: sc_illegal = 1'b1;
        endcase
    end

    // One shift-add step: add the (pre-shifted) multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        if (bus.Function == OpMul) begin
                            mcand_q  <= {{WIDTH{1'b0}}, bus.dataa};
                            mplier_q <= bus.datab;
                            acc_q    <= '0;
                            cnt_q    <= CW'(WIDTH);
                            state_q  <= StBusy;
                        end else begin
                            result_q   <= sc_result;
                            zero_q     <= (sc_result == '0);
                            carry_q    <= sc_carry;
                            overflow_q <= sc_overflow;
                            illegal_q  <= sc_illegal;
                            state_q    <= StDone;
                        end
                    end
                end
                StBusy: begin
                    acc_q    <= acc_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q   <= acc_nxt[WIDTH-1:0];
                        zero_q     <= (acc_nxt[WIDTH-1:0] == '0);
                        carry_q    <= 1'b0;
                        overflow_q <= |acc_nxt[2*WIDTH-1:WIDTH];
                        illegal_q  <= 1'b0;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !reset;
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32) with hand-computed expected results and flags.
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, return the result, flags {zero,carry,overflow,illegal} and the number
    // of edges between the accept edge and out_valid; then drain it with out_ready=1.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] f, output int w);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            step();
            guard++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready=%b, required 1", bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.Function  = op;
        bus.dataa     = a;
        bus.datab     = b;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 100) begin
            step();
            w++;
        end
        r = bus.result;
        f = {bus.zero, bus.carry, bus.overflow, bus.illegal};
        step();
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.Function  = 4'b0000;
        bus.dataa     = '0;
        bus.datab     = '0;
        step();
        step();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.carry, bus.overflow,
             bus.illegal} !== 38'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b r=%h f=%b, required all 0", bus.in_ready,
                     bus.out_valid, bus.result,
                     {bus.zero, bus.carry, bus.overflow, bus.illegal});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_add();
        logic [31:0] r;
        logic [3:0]  f;
        int          w;
        do_op(4'b0000, 32'hFFFF_FFFF, 32'h1, r, f, w);
        n_checks++;
        if (r !== 32'h0 || f !== 4'b1100 || w !== 0) begin
            n_fail++;
            $display("FAIL add_wrap: r=%h f=%b w=%0d, required r=00000000 f=1100 w=0", r, f, w);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_drain: vld=%b rdy=%b, required vld=0 rdy=1", bus.out_valid,
                     bus.in_ready);
        end
        do_op(4'b0000, 32'h7FFF_FFFF, 32'h1, r, f, w);
        n_checks++;
        if (r !== 32'h8000_0000 || f !== 4'b0010 || w !== 0) begin
            n_fail++;
            $display("FAIL add_ovf: r=%h f=%b w=%0d, required r=80000000 f=0010 w=0", r, f, w);
        end
    endtask

    task automatic test_sub();
        logic [31:0] r;
        logic [3:0]  f;
        int          w;
        do_op(4'b0010, 32'h8000_0000, 32'h1, r, f, w);
        n_checks++;
        if (r !== 32'h7FFF_FFFF || f !== 4'b0110 || w !== 0) begin
            n_fail++;
            $display("FAIL sub_ovf: r=%h f=%b w=%0d, required r=7fffffff f=0110 w=0", r, f, w);
        end
        do_op(4'b0010, 32'h1, 32'h2, r, f, w);
        n_checks++;
        if (r !== 32'hFFFF_FFFF || f !== 4'b0000 || w !== 0) begin
            n_fail++;
            $display("FAIL sub_borrow: r=%h f=%b w=%0d, required r=ffffffff f=0000 w=0", r, f, w);
        end
    endtask

    task automatic test_logic_shift();
        logic [3:0]  ops [8] = '{4'b0100, 4'b0101, 4'b0110, 4'b0111,
                                 4'b1001, 4'b1010, 4'b1000, 4'b1000};
        logic [31:0] as  [8] = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                                 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1};
        logic [31:0] bs  [8] = '{32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00,
                                 32'h24, 32'h24, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] ers [8] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h000F_000F, 32'h0FF0_0FF0,
                                 32'hF800_0000, 32'h0800_0000, 32'h1, 32'h8000_0000};
        logic [31:0] r;
        logic [3:0]  f;
        int          w;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], as[i], bs[i], r, f, w);
            n_checks++;
            if (r !== ers[i] || f !== 4'b0000 || w !== 0) begin
                n_fail++;
                $display("FAIL logic_shift[%0d]: r=%h f=%b w=%0d, required r=%h f=0000 w=0",
                         i, r, f, w, ers[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] r;
        logic [3:0]  f;
        int          w;
        do_op(4'b0011, 32'h0001_0000, 32'h0001_0000, r, f, w);
        n_checks++;
        if (r !== 32'h0 || f !== 4'b1010 || w !== 32) begin
            n_fail++;
            $display("FAIL mul_trunc: r=%h f=%b w=%0d, required r=00000000 f=1010 w=32", r, f, w);
        end
        do_op(4'b0011, 32'd7, 32'd6, r, f, w);
        n_checks++;
        if (r !== 32'h2A || f !== 4'b0000 || w !== 32) begin
            n_fail++;
            $display("FAIL mul_small: r=%h f=%b w=%0d, required r=0000002a f=0000 w=32", r, f, w);
        end
        do_op(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, f, w);
        n_checks++;
        if (r !== 32'h1 || f !== 4'b0010 || w !== 32) begin
            n_fail++;
            $display("FAIL mul_max: r=%h f=%b w=%0d, required r=00000001 f=0010 w=32", r, f, w);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.Function  = 4'b0000;
        bus.dataa     = 32'd3;
        bus.datab     = 32'd4;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.dataa = 32'd100 + 32'(i);
            bus.datab = 32'd50 * 32'(i + 1);
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== 32'd7 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: vld=%b r=%h rdy=%b, required vld=1 r=00000007 rdy=0",
                         i, bus.out_valid, bus.result, bus.in_ready);
            end
            step();
        end
        bus.dataa     = 32'd10;
        bus.datab     = 32'd20;
        bus.out_ready = 1'b1;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release: vld=%b rdy=%b, required vld=0 rdy=1", bus.out_valid,
                     bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'd30) begin
            n_fail++;
            $display("FAIL pending_accept: vld=%b r=%h, required vld=1 r=0000001e",
                     bus.out_valid, bus.result);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] r;
        logic [3:0]  f;
        int          w;
        int          seen = 0;
        bus.in_valid  = 1'b1;
        bus.Function  = 4'b0011;
        bus.dataa     = 32'd7;
        bus.datab     = 32'd6;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_mul_reset: rdy=%b vld=%b, required rdy=0 vld=0", bus.in_ready,
                     bus.out_valid);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ready: in_ready=%b, required 1", bus.in_ready);
        end
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) seen++;
            step();
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL aborted_no_valid: out_valid cycles=%0d, required 0", seen);
        end
        do_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, r, f, w);
        n_checks++;
        if (r !== 32'h0 || f !== 4'b1001 || w !== 0) begin
            n_fail++;
            $display("FAIL illegal_f: r=%h f=%b w=%0d, required r=00000000 f=1001 w=0", r, f, w);
        end
        do_op(4'b0001, 32'hFFFF_FFFF, 32'h1, r, f, w);
        n_checks++;
        if (r !== 32'h0 || f !== 4'b1001 || w !== 0) begin
            n_fail++;
            $display("FAIL illegal_1: r=%h f=%b w=%0d, required r=00000000 f=1001 w=0", r, f, w);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic_shift();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
